pipeline_hazard_unit: RTL

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

---
 rtl/pipeline_hazard_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: scoreboard-based operand forwarding and load-use stall detection.
// Ports:
//   clk_i, reset_ni                 clock, asynchronous active-low reset
//   dec_valid_i                     decode slot holds a real instruction
//   dec_rs_i/dec_rt_i               decode source registers, qualified by dec_uses_rs_i/dec_uses_rt_i
//   dec_regwrite_i/dec_wr_regnum_i  decode destination write enable and register
//   dec_memread_i                   decode instruction is a load
//   flush_i                         decode slot is wrong-path
//   stall_o                         hold PC and decode register
//   fwd_a_o/fwd_b_o                 operand source: 0 = regfile, k = stage k result
//   stall_count_o/flush_count_o     saturating event counters
module pipeline_hazard_unit #(
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        dec_valid_i,
  input  logic [4:0]  dec_rs_i,
  input  logic [4:0]  dec_rt_i,
  input  logic        dec_uses_rs_i,
  input  logic        dec_uses_rt_i,
  input  logic        dec_regwrite_i,
  input  logic [4:0]  dec_wr_regnum_i,
  input  logic        dec_memread_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [2:0]  fwd_a_o,
  output logic [2:0]  fwd_b_o,
  output logic [15:0] stall_count_o,
  output logic [15:0] flush_count_o
);
  logic [STAGES:1]      vld_q, vld_d, rw_q, rw_d, mr_q, mr_d, wr_en;
  logic [STAGES:1][4:0] rn_q, rn_d;
  logic [15:0]          stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [3:0]           hit_a, hit_b;
  logic                 blk_a, blk_b, stall, take;

  // Returns {is_load, stage} of the youngest writing entry targeting r, or 0.
  // Scanning oldest to youngest lets younger matches overwrite older ones.
  function automatic logic [3:0] youngest(input logic [4:0] r, input logic [STAGES:1] w,
                                          input logic [STAGES:1] m, input logic [STAGES:1][4:0] n);
    logic [3:0] res;
    res = '0;
    for (int k = STAGES; k >= 1; k--)
      if (w[k] && n[k] == r) res = {m[k], 3'(k)};
    return res;
  endfunction

  always_comb begin
    wr_en = '0;
    for (int k = 1; k <= STAGES; k++) wr_en[k] = vld_q[k] & rw_q[k] & (|rn_q[k]);
    hit_a = dec_uses_rs_i ? youngest(dec_rs_i, wr_en, mr_q, rn_q) : 4'd0;
    hit_b = dec_uses_rt_i ? youngest(dec_rt_i, wr_en, mr_q, rn_q) : 4'd0;
    // A load younger than LOAD_STAGE has no data yet and shadows any older producer.
    blk_a = hit_a[3] && int'(hit_a[2:0]) < LOAD_STAGE;
    blk_b = hit_b[3] && int'(hit_b[2:0]) < LOAD_STAGE;
    stall = dec_valid_i & (blk_a | blk_b) & ~flush_i;
    take  = dec_valid_i & ~stall & ~flush_i;
    vld_d = vld_q << 1;
    rw_d  = rw_q << 1;
    mr_d  = mr_q << 1;
    rn_d  = rn_q << 5;
    vld_d[1] = take;
    rw_d[1]  = take & dec_regwrite_i;
    mr_d[1]  = take & dec_memread_i;
    rn_d[1]  = take ? dec_wr_regnum_i : 5'd0;
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush_i && dec_valid_i && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vld_q       <= '0;
      rw_q        <= '0;
      mr_q        <= '0;
      rn_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      rw_q        <= rw_d;
      mr_q        <= mr_d;
      rn_q        <= rn_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_o       = stall;
  assign fwd_a_o       = blk_a ? 3'd0 : hit_a[2:0];
  assign fwd_b_o       = blk_b ? 3'd0 : hit_b[2:0];
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;
endmodule
